// File: rtl/palette_loader.sv
// Palette download feeder: assembles R,G,B bytes from the host download stream
// into 24-bit entries, buffers them and writes them to the palette RAM only during blanking.
module palette_loader #(
  parameter int NUM_ENTRIES = 64,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  input  logic        hblank,
  input  logic        vblank,
  output logic        load_color,
  output logic [5:0]  load_color_index,
  output logic [23:0] load_color_data,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int TOTAL_BYTES = 3 * NUM_ENTRIES;
  localparam int AW          = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, FINISH} state_t;

  state_t       state_reg, state_next;
  logic         download_prev;
  logic         download_rise, download_fall;
  logic [1:0]   lane_reg;
  logic [5:0]   entry_reg;
  logic [10:0]  byte_cnt_reg;
  logic [7:0]   red_reg, green_reg;

  logic [29:0]  fifo_mem [FIFO_DEPTH];
  logic [AW:0]  wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]  fifo_count;
  logic         fifo_empty, fifo_full;

  logic         start, accept, push, pop, drain_active;

  assign download_rise = ioctl_download & ~download_prev;
  assign download_fall = ~ioctl_download & download_prev;

  assign fifo_count = wr_ptr_reg - rd_ptr_reg;
  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == (AW+1)'(FIFO_DEPTH));

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (download_rise) state_next = LOAD;
      LOAD:    if (download_fall) state_next = DRAIN;
      DRAIN:   if (fifo_empty && !load_color) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    busy         = (state_reg != IDLE);
    done         = (state_reg == FINISH);
    start        = (state_reg == IDLE) && download_rise;
    drain_active = (state_reg == LOAD) || (state_reg == DRAIN);
    accept       = (state_reg == LOAD) && ioctl_wr && (byte_cnt_reg < 11'(TOTAL_BYTES));
    push         = accept && (lane_reg == 2'd2) && !fifo_full;
    pop          = drain_active && (hblank || vblank) && !fifo_empty;
  end

  // Byte assembly and download bookkeeping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      download_prev <= 1'b0;
      lane_reg      <= '0;
      entry_reg     <= '0;
      byte_cnt_reg  <= '0;
      red_reg       <= '0;
      green_reg     <= '0;
      error         <= 1'b0;
    end else begin
      download_prev <= ioctl_download;
      if (start) begin
        lane_reg     <= '0;
        entry_reg    <= '0;
        byte_cnt_reg <= '0;
        error        <= 1'b0;
      end else if (state_reg == LOAD) begin
        if (ioctl_wr && byte_cnt_reg != 11'h7FF)
          byte_cnt_reg <= byte_cnt_reg + 11'd1;
        if (accept) begin
          case (lane_reg)
            2'd0:    begin red_reg   <= ioctl_dout; lane_reg <= 2'd1; end
            2'd1:    begin green_reg <= ioctl_dout; lane_reg <= 2'd2; end
            default: begin entry_reg <= entry_reg + 6'd1; lane_reg <= 2'd0; end
          endcase
        end
        if (download_fall)
          error <= (byte_cnt_reg != 11'(TOTAL_BYTES));
      end
    end
  end

  // Entry storage (no reset so it maps to RAM)
  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr_reg[AW-1:0]] <= {entry_reg, red_reg, green_reg, ioctl_dout};
  end

  // FIFO pointers, back-pressure and palette write port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      ioctl_wait       <= 1'b0;
      load_color       <= 1'b0;
      load_color_index <= '0;
      load_color_data  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      // One cycle behind occupancy; the threshold leaves room for the in-flight entry.
      ioctl_wait <= (fifo_count >= (AW+1)'(FIFO_DEPTH - 1));
      load_color <= pop;
      if (pop) begin
        load_color_index <= fifo_mem[rd_ptr_reg[AW-1:0]][29:24];
        load_color_data  <= fifo_mem[rd_ptr_reg[AW-1:0]][23:0];
      end
    end
  end

endmodule

// File: tb/tb_palette_loader.sv
// Randomized scoreboard bench for palette_loader: the host model queues expected
// palette writes, an independent monitor pops and compares every load_color pulse.
module tb_palette_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [7:0]  ioctl_dout = 8'h00;
  logic        ioctl_wait;
  logic        hblank = 1'b0;
  logic        vblank = 1'b0;
  logic        load_color;
  logic [5:0]  load_color_index;
  logic [23:0] load_color_data;
  logic        busy, done, error;

  always #5 clk = ~clk;

  palette_loader dut (
    .clk(clk), .reset_n(reset_n),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait), .hblank(hblank), .vblank(vblank),
    .load_color(load_color), .load_color_index(load_color_index),
    .load_color_data(load_color_data), .busy(busy), .done(done), .error(error)
  );

  typedef struct packed {
    logic [5:0]  idx;
    logic [23:0] data;
  } ent_t;

  ent_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   writes = 0;
  int   done_cnt = 0;
  bit   wait_seen = 0;
  bit   prev_blank = 0;
  int   blank_mode = 0;  // 0: vblank held, 1: hblank 20 on / 321 off, 2: no blank for 2000 cycles
  int   line_cnt = 0;
  int   bp_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Blank generator
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (blank_mode)
        0: begin vblank = 1'b1; hblank = 1'b0; end
        1: begin
          vblank = 1'b0;
          hblank = (line_cnt < 20);
          line_cnt = (line_cnt == 340) ? 0 : line_cnt + 1;
        end
        default: begin
          hblank = 1'b0;
          vblank = (bp_cnt >= 2000);
          bp_cnt++;
        end
      endcase
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (reset_n) begin
      if (ioctl_wait) wait_seen = 1;
      if (load_color) begin
        writes++;
        chk("write_in_blank", {31'd0, prev_blank}, 32'd1);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: idx %0d data %06h with nothing pending",
                   load_color_index, load_color_data);
        end else begin
          ent_t e;
          e = exp_q.pop_front();
          chk("write_index", {26'd0, load_color_index}, {26'd0, e.idx});
          chk("write_data", {8'd0, load_color_data}, {8'd0, e.data});
          $display("write idx=%0d data=%06h", load_color_index, load_color_data);
        end
      end
      if (done) done_cnt++;
      prev_blank = hblank | vblank;
    end else begin
      prev_blank = 0;
    end
  end

  // Host model: sends bytes obeying ioctl_wait and records the expected palette writes
  task automatic send_bytes(input int n, input bit ramp);
    logic [7:0] r, g, b_val;
    r = 8'h00;
    g = 8'h00;
    for (int b = 0; b < n; b++) begin
      int t;
      logic [7:0] v;
      t = 0;
      while (ioctl_wait && t < 20000) begin
        cycle();
        t++;
      end
      if (t >= 20000) begin
        n_checks++;
        n_fail++;
        $display("FAIL wait_timeout: ioctl_wait stuck high at byte %0d", b);
      end
      v = ramp ? 8'((b / 3) + (b % 3)) : 8'($urandom_range(0, 255));
      if (b < 192) begin
        case (b % 3)
          0: r = v;
          1: g = v;
          default: begin
            b_val = v;
            exp_q.push_back({6'(b / 3), r, g, b_val});
          end
        endcase
      end
      ioctl_wr = 1'b1;
      ioctl_dout = v;
      cycle();
      ioctl_wr = 1'b0;
      repeat ($urandom_range(0, 2)) cycle();
    end
  endtask

  task automatic run_download(input string tag, input int nbytes, input bit ramp,
                              input int exp_writes, input bit exp_err);
    int w0, d0, t;
    w0 = writes;
    d0 = done_cnt;
    ioctl_download = 1'b1;
    repeat (2) cycle();
    chk({tag, "_busy_start"}, {31'd0, busy}, 32'd1);
    chk({tag, "_error_cleared"}, {31'd0, error}, 32'd0);
    send_bytes(nbytes, ramp);
    repeat (2) cycle();
    ioctl_download = 1'b0;
    t = 0;
    while (done_cnt == d0 && t < 30000) begin
      cycle();
      t++;
    end
    repeat (2) cycle();
    chk({tag, "_writes"}, 32'(writes - w0), 32'(exp_writes));
    chk({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, "_error"}, {31'd0, error}, {31'd0, exp_err});
    chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    $display("download %s: bytes=%0d writes=%0d error=%0b", tag, nbytes, writes - w0, error);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_load_color"}, {31'd0, load_color}, 32'd0);
    chk({tag, "_index"}, {26'd0, load_color_index}, 32'd0);
    chk({tag, "_data"}, {8'd0, load_color_data}, 32'd0);
    chk({tag, "_wait"}, {31'd0, ioctl_wait}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_error"}, {31'd0, error}, 32'd0);
  endtask

  initial begin
    int d0;
    repeat (3) cycle();
    chk_outputs_zero("reset");
    reset_n = 1'b1;
    repeat (3) cycle();

    // Full ramp load with vblank held
    blank_mode = 0;
    run_download("full", 192, 1'b1, 64, 1'b0);
    chk("full_last_index", {26'd0, load_color_index}, 32'd63);
    chk("full_last_data", {8'd0, load_color_data}, 32'h003F4041);

    // Blank gating through short hblank windows
    blank_mode = 1;
    wait_seen = 0;
    run_download("gated", 192, 1'b0, 64, 1'b0);
    chk("gated_wait_seen", {31'd0, wait_seen}, 32'd1);

    blank_mode = 0;
    run_download("short", 100, 1'b0, 33, 1'b1);
    run_download("long", 200, 1'b0, 64, 1'b1);
    run_download("empty", 0, 1'b0, 0, 1'b1);

    // Asynchronous reset in the middle of a download
    ioctl_download = 1'b1;
    repeat (2) cycle();
    send_bytes(30, 1'b1);
    @(posedge clk);
    #2;
    d0 = done_cnt;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk_outputs_zero("midreset");
    ioctl_download = 1'b0;
    repeat (3) cycle();
    reset_n = 1'b1;
    repeat (5) cycle();
    chk("midreset_no_done", 32'(done_cnt), 32'(d0));
    run_download("after_reset", 192, 1'b0, 64, 1'b0);

    // Back-pressure with blank held low for 2000 cycles
    bp_cnt = 0;
    wait_seen = 0;
    blank_mode = 2;
    run_download("backpressure", 192, 1'b0, 64, 1'b0);
    chk("backpressure_wait_seen", {31'd0, wait_seen}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
